// File: rtl/noc_out_arbiter.sv
// Output-port arbiter: locks one input FIFO per packet and streams its flits through a
// 2-entry credit-managed output buffer. Define NOC_ARB_RR_EN for round-robin selection.
module noc_out_arbiter #(
    parameter int DATA_WIDTH = 37,
    parameter int NUM_IN     = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_IN-1:0]            fifo_empty,
    input  logic [NUM_IN*DATA_WIDTH-1:0] fifo_data,
    output logic [NUM_IN-1:0]            fifo_rd_en,
    output logic                         out_valid,
    output logic [DATA_WIDTH-1:0]        out_data,
    input  logic                         out_ready,
    output logic [NUM_IN-1:0]            grant
);
    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t                state_q, state_d;
    logic [NUM_IN-1:0]     grant_q, grant_d;
    logic [1:0]            occ_q, occ_d;
    logic                  inflight_q, inflight_d;
    logic                  tail_cap_q, tail_cap_d;
    logic                  started_q;
    logic [DATA_WIDTH-1:0] head_q, head_d, next_q, next_d;
    logic [NUM_IN-1:0]     sel_onehot;
    logic                  any_req, pop, credit_ok, leaving;
    logic [DATA_WIDTH-1:0] in_data;

    assign out_valid = (occ_q != 2'd0);
    assign out_data  = head_q;
    assign grant     = grant_q;

    always_comb begin
        in_data = '0;
        for (int i = 0; i < NUM_IN; i++)
            if (grant_q[i]) in_data = fifo_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

`ifdef NOC_ARB_RR_EN
    localparam int PW = $clog2(NUM_IN);
    logic [PW-1:0] ptr_q, ptr_d;

    always_comb begin
        int idx;
        idx        = 0;
        sel_onehot = '0;
        any_req    = 1'b0;
        for (int k = 0; k < NUM_IN; k++) begin
            idx = (int'(ptr_q) + k) % NUM_IN;
            if (!any_req && !fifo_empty[idx]) begin
                sel_onehot[idx] = 1'b1;
                any_req         = 1'b1;
            end
        end
    end

    // The pointer moves past the input that just finished so it goes to the back of the line.
    always_comb begin
        ptr_d = ptr_q;
        if (leaving)
            for (int i = 0; i < NUM_IN; i++)
                if (grant_q[i]) ptr_d = PW'((i + 1) % NUM_IN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end
`else
    always_comb begin
        sel_onehot = '0;
        any_req    = ~&fifo_empty;
        for (int i = NUM_IN - 1; i >= 0; i--)
            if (!fifo_empty[i]) sel_onehot = NUM_IN'(1) << i;
    end
`endif

    // A tail captured with nothing behind it ends the lock; a flit in flight behind a tail
    // is the next packet's head from the same input, so the lock is kept for it.
    always_comb begin
        pop        = out_valid && out_ready;
        credit_ok  = ({1'b0, occ_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});
        leaving    = (state_q == LOCKED) && tail_cap_q && !inflight_q;

        fifo_rd_en = '0;
        if (started_q && credit_ok) begin
            if (state_q == IDLE) fifo_rd_en = sel_onehot;
            else if (!leaving)   fifo_rd_en = grant_q & ~fifo_empty;
        end

        state_d = state_q;
        grant_d = grant_q;
        if (state_q == IDLE) begin
            if (started_q && any_req) begin
                state_d = LOCKED;
                grant_d = sel_onehot;
            end
        end else if (leaving) begin
            state_d = IDLE;
            grant_d = '0;
        end

        inflight_d = |fifo_rd_en;
        tail_cap_d = inflight_q && in_data[DATA_WIDTH-2];

        head_d = head_q;
        next_d = next_q;
        occ_d  = occ_q;
        if (pop && inflight_q) begin
            if (occ_q == 2'd2) begin
                head_d = next_q;
                next_d = in_data;
            end else begin
                head_d = in_data;
            end
        end else if (pop) begin
            head_d = next_q;
            occ_d  = occ_q - 2'd1;
        end else if (inflight_q) begin
            if (occ_q == 2'd0) head_d = in_data;
            else               next_d = in_data;
            occ_d = occ_q + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            tail_cap_q <= 1'b0;
            started_q  <= 1'b0;
            head_q     <= '0;
            next_q     <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            tail_cap_q <= tail_cap_d;
            started_q  <= 1'b1;
            head_q     <= head_d;
            next_q     <= next_d;
        end
    end
endmodule

// File: doc/noc_out_arbiter.md
NOC_OUT_ARBITER -- requirements
Module: noc_out_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 37, SHALL set the flit width; bit DATA_WIDTH-2 is the tail bit.
REQ-002 Parameter NUM_IN, default 4, SHALL set the number of input FIFOs arbitrated, and SHALL be at least 2.
REQ-003 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 fifo_empty  input  NUM_IN  per-input FIFO empty flag.
REQ-006 fifo_data  input  NUM_IN*DATA_WIDTH  per-input FIFO read data, valid one cycle after the matching rd_en; input i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 fifo_rd_en  output  NUM_IN  per-input FIFO read strobe, at most one bit high per cycle.
REQ-008 out_valid  output  1  out_data holds a flit.
REQ-009 out_data  output  DATA_WIDTH  head of the output buffer.
REQ-010 out_ready  input  1  downstream accepts the flit; a transfer occurs when out_valid and out_ready are both high.
REQ-011 grant  output  NUM_IN  one-hot locked input, or zero when idle.

Function
REQ-012 The block SHALL use two states: IDLE (grant=0) and LOCKED (grant one-hot).
REQ-013 In IDLE with any fifo_empty bit low, the block SHALL select an input per REQ-027/028, enter LOCKED, and assert that input's rd_en in the same cycle if credit allows.
REQ-014 The block SHALL never assert fifo_rd_en[i] while fifo_empty[i] is high or while i is not the granted or newly selected input.
REQ-015 Credit rule: rd_en SHALL be asserted only when occ + inflight - pop < 2, where occ is the 0..2 output buffer count, inflight is 1 if rd_en was high in the previous cycle, and pop is out_valid&&out_ready.
REQ-016 The flit read by rd_en in cycle t SHALL be captured from fifo_data at the end of cycle t+1 and appear on out_data with out_valid in cycle t+2 at the earliest.
REQ-017 The output buffer SHALL be a 2-entry FIFO that preserves order, with simultaneous capture and pop allowed.
REQ-018 With out_ready held high and a non-empty granted input, the block SHALL sustain one flit per cycle.
REQ-019 When a captured flit has its tail bit set and inflight=0, the block SHALL return to IDLE in the next cycle.
REQ-020 When a captured flit has its tail bit set and inflight=1, the in-flight flit is the head of the next packet from the same input, so LOCKED SHALL persist until that packet's tail is captured.
REQ-021 While LOCKED, if the granted FIFO is empty, the block SHALL hold grant and stall without reading until it is non-empty; other inputs SHALL NOT be read.
REQ-022 With out_ready low, out_valid and out_data SHALL remain stable until transfer.
REQ-023 Flits SHALL NOT be dropped, duplicated or reordered.

Reset
REQ-024 On rst high, outputs SHALL immediately be: out_valid=0, out_data=0, fifo_rd_en=0, grant=0; the state SHALL be IDLE, occ=0, inflight=0 and the round-robin pointer 0.
REQ-025 Assertion of rst mid-packet SHALL discard buffered and in-flight flits, with no partial-packet recovery.
REQ-026 After rst deasserts, the first rd_en SHALL occur no earlier than the first rising edge at which rst is low.

Configuration
REQ-027 With macro NOC_ARB_RR_EN defined, selection SHALL be round-robin: search starts at the pointer, and the pointer SHALL be set to granted index+1 (mod NUM_IN) when the block returns to IDLE.
REQ-028 Without NOC_ARB_RR_EN, selection SHALL be fixed priority (lowest non-empty index wins), and the pointer logic SHALL be absent.

Verification
REQ-029 Single input: input 2 holds flits H,B,T (tail on T) with out_ready=1 -> rd_en[2] in cycles 0,1,2; out_valid in cycles 2,3,4 with data H,B,T; grant returns to 0 in cycle 5.
REQ-030 Backpressure: out_ready=0 for 5 cycles mid-packet -> at most 2 flits buffered, no rd_en while occ+inflight=2, out_data stable, order intact on resume.
REQ-031 Round-robin (NOC_ARB_RR_EN): inputs 0..3 each hold one 1-flit packet -> packets egress in order 0,1,2,3; a refilled input 0 then waits behind 1..3.
REQ-032 Fixed priority (no macro): inputs 0 and 3 continuously non-empty -> only input 0 is served; input 3 starves.
REQ-033 Back-to-back packets on one input: tail then head in flight -> grant stays on the same input and no other rd_en bit toggles.
REQ-034 Reset mid-packet: rst pulsed while out_valid=1 -> out_valid, rd_en and grant are 0 in the same cycle; a new packet is accepted cleanly afterwards.
